// File: rtl/tlv5638_pkg.sv
// Shared definitions for the TLV5638 control and serial transmit blocks:
// transmitter state encoding, DAC word width and control-word field codes.
package tlv5638_pkg;

  localparam int DAC_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } tx_state_t;

  // R1:R0 register select, carried in word bits 15 and 12
  localparam logic [1:0] SEL_DAC_B  = 2'b00;
  localparam logic [1:0] SEL_BUFFER = 2'b01;
  localparam logic [1:0] SEL_DAC_A  = 2'b10;
  localparam logic [1:0] SEL_CTRL   = 2'b11;

  // Reference select codes in control-register bits 1:0
  localparam logic [1:0] REF_1V024 = 2'b01;
  localparam logic [1:0] REF_2V048 = 2'b10;

  // Speed and power bits (word bits 14 and 13)
  localparam logic SPD_FAST   = 1'b1;
  localparam logic PWR_DOWN   = 1'b1;

  // Control-register write: {R1, SPD, PWR, R0, 10'b0, REF}
  function automatic logic [DAC_WORD_W-1:0] ctrl_word(input logic spd,
                                                      input logic [1:0] ref_sel);
    return {SEL_CTRL[1], spd, 1'b0, SEL_CTRL[0], 10'd0, ref_sel};
  endfunction

endpackage

// File: rtl/tlv5638_spi_tx_sclk_tick_gen.sv
// Half-period tick generator for SCLK. While clr is low it counts CLK_DIV
// cycles per half-period, starting in the high phase, and flags the last
// cycle of each phase so the transmitter can register the SCLK edge.
module sclk_tick_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk_20M,
  input  logic rst_n,
  input  logic clr,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          low_phase;
  logic          last;

  assign last     = (cnt == LAST);
  assign fall_stb = !clr && last && !low_phase;
  assign rise_stb = !clr && last && low_phase;

  // Half-period counter and phase flag, held at the start of a high phase while cleared
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      low_phase <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      low_phase <= 1'b0;
    end else if (last) begin
      cnt       <= '0;
      low_phase <= !low_phase;
    end else begin
      cnt       <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tlv5638_spi_tx.sv
// TLV5638 3-wire serial transmitter. Latches the upstream config word in
// LOAD, frames it with CS_n and shifts it MSB-first on SCLK falling edges.
// irq spans latch to frame end; its falling edge asks for the next word,
// which is not sampled again until GAP_CYC cycles later.
module tlv5638_spi_tx
  import tlv5638_pkg::*;
#(
  parameter int CLK_DIV  = 10,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic                  clk_20M,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DAC_WORD_W-1:0] config_reg,
  output logic                  sclk,
  output logic                  din,
  output logic                  cs_n,
  output logic                  irq,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ?
                           ((CS_SETUP > GAP_CYC) ? CS_SETUP : GAP_CYC) :
                           ((CS_HOLD  > GAP_CYC) ? CS_HOLD  : GAP_CYC);
  localparam int DW = $clog2(DLY_MAX + 1);

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [DW-1:0]         dly_cnt;
  logic [3:0]            bit_cnt;
  logic [DAC_WORD_W-1:0] shift_reg;
  logic                  rise_stb;
  logic                  fall_stb;

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_20M  (clk_20M),
    .rst_n    (rst_n),
    .clr      (state != ST_SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // State register
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: timed states exit when the shared delay counter reaches zero
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SETUP;
      ST_SETUP: if (dly_cnt == '0) state_nxt = ST_SHIFT;
      ST_SHIFT: if (rise_stb && bit_cnt == 4'd0) state_nxt = ST_HOLD;
      ST_HOLD:  if (dly_cnt == '0) state_nxt = ST_GAP;
      ST_GAP:   if (dly_cnt == '0) state_nxt = en ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Word capture; only ever sampled in LOAD, so no reset is needed
  always_ff @(posedge clk_20M) begin
    if (state == ST_LOAD) shift_reg <= config_reg;
  end

  // Registered pin outputs, delay counter and bit counter
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      sclk       <= 1'b1;
      din        <= 1'b0;
      cs_n       <= 1'b1;
      irq        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dly_cnt    <= '0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      busy       <= (state_nxt != ST_IDLE);
      case (state)
        ST_LOAD: begin
          irq     <= 1'b1;
          cs_n    <= 1'b0;
          sclk    <= 1'b1;
          din     <= config_reg[DAC_WORD_W-1];
          dly_cnt <= DW'(CS_SETUP - 1);
          bit_cnt <= 4'(DAC_WORD_W - 1);
        end
        ST_SETUP: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - DW'(1);
        end
        ST_SHIFT: begin
          if (fall_stb) sclk <= 1'b0;
          if (rise_stb) begin
            sclk <= 1'b1;
            // din only moves on the rising edge, so it is stable across the DAC's falling-edge sample
            if (bit_cnt != 4'd0) begin
              bit_cnt <= bit_cnt - 4'd1;
              din     <= shift_reg[bit_cnt - 4'd1];
            end else begin
              dly_cnt <= DW'(CS_HOLD - 1);
            end
          end
        end
        ST_HOLD: begin
          if (dly_cnt == '0) begin
            cs_n       <= 1'b1;
            irq        <= 1'b0;
            frame_done <= 1'b1;
            din        <= 1'b0;
            dly_cnt    <= DW'(GAP_CYC - 1);
          end else begin
            dly_cnt <= dly_cnt - DW'(1);
          end
        end
        ST_GAP: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlv5638_spi_tx.sv
// Bench for tlv5638_spi_tx: one instance at default timing, one at the
// fastest timing. A pin-level monitor rebuilds each CS_n frame from the
// SCLK falling edges; the main sequence compares frames with words and
// timing derived from the frame-period arithmetic.
`timescale 1ns/1ps
module tb_tlv5638_spi_tx;
  import tlv5638_pkg::*;

  localparam int DIV_A = 10, SET_A = 2, HOLD_A = 2, GAP_A = 4;
  localparam int DIV_B = 1,  SET_B = 1, HOLD_B = 1, GAP_B = 2;
  localparam int LOW_A    = SET_A + 32 * DIV_A + HOLD_A;
  localparam int LOW_B    = SET_B + 32 * DIV_B + HOLD_B;
  localparam int PERIOD_A = 1 + LOW_A + GAP_A;
  localparam int PERIOD_B = 1 + LOW_B + GAP_B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic [15:0] cfg_a, cfg_b;
  logic [1:0]  sclk, din, cs_n, irq, busy, fdone;
  int          cyc = 0;

  always #25 clk = ~clk;

  // Free-running cycle index used for all timing measurements
  always @(posedge clk) cyc <= cyc + 1;

  tlv5638_spi_tx #(.CLK_DIV(DIV_A), .CS_SETUP(SET_A), .CS_HOLD(HOLD_A), .GAP_CYC(GAP_A)) dut_a (
    .clk_20M(clk), .rst_n(rst_n), .en(en[0]), .config_reg(cfg_a),
    .sclk(sclk[0]), .din(din[0]), .cs_n(cs_n[0]), .irq(irq[0]),
    .busy(busy[0]), .frame_done(fdone[0]));

  tlv5638_spi_tx #(.CLK_DIV(DIV_B), .CS_SETUP(SET_B), .CS_HOLD(HOLD_B), .GAP_CYC(GAP_B)) dut_b (
    .clk_20M(clk), .rst_n(rst_n), .en(en[1]), .config_reg(cfg_b),
    .sclk(sclk[1]), .din(din[1]), .cs_n(cs_n[1]), .irq(irq[1]),
    .busy(busy[1]), .frame_done(fdone[1]));

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          cs_fall;
    int          cs_rise;
    int          last_rise;
    bit          spacing_ok;
    bit          din_ok;
    bit          irq_ok;
    bit          fd_ok;
  } frame_t;

  typedef struct {
    logic [15:0] cfg;
    logic [15:0] exp_word;
    int          exp_lat;
    int          exp_low;
  } vec_t;

  frame_t fq_a[$];
  frame_t fq_b[$];
  int     mon_nbits [2];
  int     n_fd [2];
  int     n_chk = 0;
  int     n_pass = 0;

  function automatic int div_of(input int d);
    return (d == 0) ? DIV_A : DIV_B;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic set_cfg(input int d, input logic [15:0] w);
    if (d == 0) cfg_a = w;
    else        cfg_b = w;
  endtask

  task automatic get_frame(input int d, input int budget, output frame_t f, output bit ok);
    ok = 1'b0;
    f  = '{default: 0};
    for (int i = 0; i < budget; i++) begin
      if (d == 0 && fq_a.size() > 0) begin f = fq_a.pop_front(); ok = 1'b1; break; end
      if (d == 1 && fq_b.size() > 0) begin f = fq_b.pop_front(); ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_irq_fall(input int d, input int budget, output bit ok);
    logic p;
    p  = irq[d];
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (p && !irq[d]) begin ok = 1'b1; break; end
      p = irq[d];
    end
  endtask

  task automatic wait_nbits(input int d, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cs_n[d] && mon_nbits[d] == n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chk_frame(input string nm, input frame_t f, input int d, input logic [15:0] w);
    chk({nm, "_word"}, f.word, w);
    chk({nm, "_nbits"}, f.nbits, 16);
    chk({nm, "_cs_low"}, f.cs_rise - f.cs_fall, (d == 0) ? LOW_A : LOW_B);
    chk({nm, "_fall_spacing"}, f.spacing_ok, 1);
    chk({nm, "_din_stable"}, f.din_ok, 1);
    chk({nm, "_irq_high"}, f.irq_ok, 1);
    chk({nm, "_frame_done"}, f.fd_ok, 1);
    chk({nm, "_cs_hold"}, f.cs_rise - f.last_rise, (d == 0) ? HOLD_A : HOLD_B);
  endtask

  // Idle-state check a few cycles after a frame: busy low, no new frame started
  task automatic chk_idle(input string nm, input int d);
    repeat (((d == 0) ? GAP_A : GAP_B) + 3) @(negedge clk);
    chk({nm, "_busy_idle"}, busy[d], 0);
    repeat (40) @(negedge clk);
    chk({nm, "_no_extra_frame"}, (d == 0) ? fq_a.size() : fq_b.size(), 0);
    chk({nm, "_cs_idle"}, cs_n[d], 1);
  endtask

  // Continuous transmission fed by an upstream model that presents the next word on each irq fall
  task automatic run_stream(input int d, input int nfr);
    logic [15:0] words [8];
    frame_t      f, pf;
    bit          ok;
    for (int i = 0; i < nfr; i++) begin
      if (d == 0 && i == 0)      words[i] = 16'hD002;
      else if (d == 0 && i == 1) words[i] = 16'h5ABC;
      else if (d == 0 && i == 2) words[i] = 16'hC123;
      else                       words[i] = 16'($urandom);
    end
    @(negedge clk);
    set_cfg(d, words[0]);
    en[d] = 1'b1;
    for (int i = 0; i < nfr; i++) begin
      wait_irq_fall(d, 2000, ok);
      chk("stream_irq_fall", ok, 1);
      if (i < nfr - 1) set_cfg(d, words[i + 1]);
      else             en[d] = 1'b0;
    end
    pf = '{default: 0};
    for (int i = 0; i < nfr; i++) begin
      get_frame(d, 50, f, ok);
      chk("stream_frame_seen", ok, 1);
      chk_frame((d == 0) ? "stream_a" : "stream_b", f, d, words[i]);
      if (i > 0) begin
        chk("stream_period", f.cs_fall - pf.cs_fall, (d == 0) ? PERIOD_A : PERIOD_B);
        chk("stream_irq_to_cs", f.cs_fall - pf.cs_rise, ((d == 0) ? GAP_A : GAP_B) + 1);
      end
      pf = f;
    end
    chk_idle((d == 0) ? "stream_a" : "stream_b", d);
  endtask

  // Pin monitor: rebuilds frames from the SCLK falling edges while CS_n is low
  initial begin
    frame_t     cur [2];
    int         last_fall [2];
    logic [1:0] p_cs, p_sclk, p_din;
    p_cs   = 2'b11;
    p_sclk = 2'b11;
    p_din  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      cur[d] = '{default: 0};
      last_fall[d] = -1;
      mon_nbits[d] = 0;
      n_fd[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (fdone[d]) n_fd[d]++;
        if (p_cs[d] && !cs_n[d]) begin
          cur[d] = '{default: 0};
          cur[d].cs_fall    = cyc;
          cur[d].last_rise  = -1;
          cur[d].spacing_ok = 1'b1;
          cur[d].din_ok     = 1'b1;
          cur[d].irq_ok     = 1'b1;
          last_fall[d] = -1;
          mon_nbits[d] = 0;
        end
        if (!cs_n[d]) begin
          if (!irq[d]) cur[d].irq_ok = 1'b0;
          if (p_sclk[d] && !sclk[d]) begin
            cur[d].word  = {cur[d].word[14:0], din[d]};
            cur[d].nbits = cur[d].nbits + 1;
            mon_nbits[d] = cur[d].nbits;
            if (last_fall[d] >= 0 && (cyc - last_fall[d]) != 2 * div_of(d)) cur[d].spacing_ok = 1'b0;
            last_fall[d] = cyc;
          end
          if (!p_sclk[d] && sclk[d]) cur[d].last_rise = cyc;
          if (!p_cs[d] && din[d] != p_din[d] && !(!p_sclk[d] && sclk[d])) cur[d].din_ok = 1'b0;
        end
        if (!p_cs[d] && cs_n[d]) begin
          cur[d].cs_rise = cyc;
          cur[d].fd_ok   = fdone[d] && !irq[d] && sclk[d];
          if (d == 0) fq_a.push_back(cur[d]);
          else        fq_b.push_back(cur[d]);
        end
        p_cs[d]   = cs_n[d];
        p_sclk[d] = sclk[d];
        p_din[d]  = din[d];
      end
    end
  end

  // Main sequence
  initial begin
    vec_t   vt [5];
    frame_t f;
    bit     ok;
    int     en_cyc, fd0;

    rst_n = 1'b0;
    en    = 2'b00;
    cfg_a = 16'h0000;
    cfg_b = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_sclk",  sclk[0],  1);
    chk("rst_din",   din[0],   0);
    chk("rst_cs_n",  cs_n[0],  1);
    chk("rst_irq",   irq[0],   0);
    chk("rst_busy",  busy[0],  0);
    chk("rst_fdone", fdone[0], 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy[0], 0);
    chk("idle_cs_n", cs_n[0], 1);

    // Single frames started by a one-cycle en pulse
    vt[0] = '{ctrl_word(SPD_FAST, REF_2V048), 16'hD002, 2, LOW_A};
    vt[1] = '{16'h5ABC, 16'h5ABC, 2, LOW_A};
    vt[2] = '{16'h0000, 16'h0000, 2, LOW_A};
    vt[3] = '{16'hFFFF, 16'hFFFF, 2, LOW_A};
    vt[4] = '{16'h8001, 16'h8001, 2, LOW_A};
    for (int i = 0; i < 5; i++) begin
      cfg_a  = vt[i].cfg;
      fd0    = n_fd[0];
      en[0]  = 1'b1;
      en_cyc = cyc;
      @(negedge clk);
      en[0]  = 1'b0;
      chk("single_busy_load", busy[0], 1);
      get_frame(0, 2000, f, ok);
      chk("single_frame_seen", ok, 1);
      chk("single_latency", f.cs_fall - en_cyc, vt[i].exp_lat);
      chk_frame("single", f, 0, vt[i].exp_word);
      chk_idle("single", 0);
      chk("single_fd_count", n_fd[0] - fd0, 1);
    end

    // Rotating upstream words at default timing
    run_stream(0, 5);

    // en dropped during bit 9: frame still completes
    cfg_a = 16'hA5C3;
    en[0] = 1'b1;
    wait_nbits(0, 7, 2000, ok);
    chk("endrop_reach_bit9", ok, 1);
    en[0] = 1'b0;
    get_frame(0, 2000, f, ok);
    chk("endrop_frame_seen", ok, 1);
    chk_frame("endrop", f, 0, 16'hA5C3);
    chk_idle("endrop", 0);

    // config_reg changed mid-SHIFT only affects the next frame
    cfg_a = 16'hD002;
    en[0] = 1'b1;
    wait_nbits(0, 4, 2000, ok);
    chk("cfgchg_reach_bit12", ok, 1);
    cfg_a = 16'hFFFF;
    wait_irq_fall(0, 2000, ok);
    chk("cfgchg_irq_fall1", ok, 1);
    wait_irq_fall(0, 2000, ok);
    chk("cfgchg_irq_fall2", ok, 1);
    en[0] = 1'b0;
    get_frame(0, 50, f, ok);
    chk_frame("cfgchg_f1", f, 0, 16'hD002);
    get_frame(0, 50, f, ok);
    chk_frame("cfgchg_f2", f, 0, 16'hFFFF);
    chk_idle("cfgchg", 0);

    // Reset pulsed during bit 7, then a fresh frame
    cfg_a = 16'h3C96;
    en[0] = 1'b1;
    wait_nbits(0, 9, 2000, ok);
    chk("rstmid_reach_bit7", ok, 1);
    chk("rstmid_sclk_low_before", sclk[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sclk",  sclk[0],  1);
    chk("rstmid_cs_n",  cs_n[0],  1);
    chk("rstmid_din",   din[0],   0);
    chk("rstmid_irq",   irq[0],   0);
    chk("rstmid_busy",  busy[0],  0);
    chk("rstmid_fdone", fdone[0], 0);
    get_frame(0, 10, f, ok);
    chk("rstmid_partial_seen", ok, 1);
    chk("rstmid_partial_bits", f.nbits, 9);
    chk("rstmid_partial_fd", f.fd_ok, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    en_cyc = cyc;
    @(negedge clk);
    en[0]  = 1'b0;
    get_frame(0, 2000, f, ok);
    chk("rstmid_fresh_seen", ok, 1);
    chk("rstmid_fresh_latency", f.cs_fall - en_cyc, 2);
    chk_frame("rstmid_fresh", f, 0, 16'h3C96);
    chk_idle("rstmid", 0);

    // Fastest timing: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, GAP_CYC=2
    run_stream(1, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Run-length bound
  initial begin
    #(50 * 60000);
    $display("FAIL watchdog: got timeout after 60000 cycles, expected completion");
    $fatal(1);
  end

endmodule
